// File: rtl/boxcar_decimator.sv
// Block-averaging decimator: sums non-overlapping blocks of 2^L enabled samples
// and emits the block sum and its floor mean with a one-cycle valid strobe.
module boxcar_decimator #(
  parameter int WIDTH    = 16,
  parameter int MAX_LOG2 = 10
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      en_i,
  input  logic                      clr_i,
  input  logic [WIDTH-1:0]          data_i,
  input  logic [3:0]                log2_len_i,
  output logic [WIDTH-1:0]          data_o,
  output logic [WIDTH+MAX_LOG2-1:0] sum_o,
  output logic                      valid_o
);
  localparam int AW = WIDTH + MAX_LOG2;
  localparam int CW = MAX_LOG2 + 1;
  localparam logic [3:0] LMAX = 4'(MAX_LOG2);

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e                state_q, state_d;
  logic signed [AW-1:0]  acc_q, acc_d, acc_nxt, acc_shr;
  logic [CW-1:0]         cnt_q, cnt_d, cnt_nxt, cnt_tgt;
  logic [3:0]            l_q, l_d, l_eff, l_sel;
  logic [WIDTH-1:0]      data_q, data_d;
  logic [AW-1:0]         sum_q, sum_d;
  logic                  valid_q, valid_d;
  logic                  done;

  // An opening sample starts from zero, so IDLE and ACCUM share one adder.
  always_comb begin
    l_eff   = (log2_len_i > LMAX) ? LMAX : log2_len_i;
    l_sel   = (state_q == ACCUM) ? l_q : l_eff;
    acc_nxt = ((state_q == ACCUM) ? acc_q : '0) + AW'($signed(data_i));
    cnt_nxt = ((state_q == ACCUM) ? cnt_q : '0) + CW'(1);
    cnt_tgt = CW'(1) << l_sel;
    acc_shr = acc_nxt >>> l_sel;
    done    = en_i && (cnt_nxt == cnt_tgt);
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    data_d  = data_q;
    sum_d   = sum_q;
    valid_d = 1'b0;
    if (clr_i) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (en_i) begin
      acc_d   = acc_nxt;
      cnt_d   = cnt_nxt;
      l_d     = l_sel;
      state_d = ACCUM;
      if (done) begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
        sum_d   = acc_nxt;
        data_d  = acc_shr[WIDTH-1:0];
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      l_q     <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign sum_o   = sum_q;
  assign valid_o = valid_q;
endmodule

// File: tb/tb_boxcar_decimator.sv
// Scoreboard bench for boxcar_decimator: a block-level model queues expected
// (sum, mean) pairs; a negedge monitor checks strobes, held values and reset.
module tb_boxcar_decimator;
  localparam int W  = 16;
  localparam int ML = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            clr = 1'b0;
  logic [W-1:0]    din = '0;
  logic [3:0]      len = '0;
  logic [W-1:0]    data_o;
  logic [W+ML-1:0] sum_o;
  logic            valid_o;

  boxcar_decimator #(.WIDTH(W), .MAX_LOG2(ML)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clr_i(clr), .data_i(din),
    .log2_len_i(len), .data_o(data_o), .sum_o(sum_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct { longint s; longint m; } exp_t;
  exp_t   q[$];
  int     tests = 0;
  int     fails = 0;
  longint last_s = 0, last_m = 0;

  // reference model state: samples of the open block
  bit     m_open = 0;
  int     m_L = 0;
  longint m_cnt = 0, m_sum = 0;

  task automatic chk(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint floor_div(longint s, int l);
    longint d = longint'(1) << l;
    if (s >= 0) return s / d;
    return -((-s + d - 1) / d);
  endfunction

  task automatic drive(bit e, bit c, int d, int l);
    exp_t x;
    longint dv;
    @(posedge clk);
    #1;
    en = e; clr = c; din = d[W-1:0]; len = l[3:0];
    dv = longint'($signed(din));
    if (c) begin
      m_open = 0; m_cnt = 0; m_sum = 0;
    end else if (e) begin
      if (!m_open) begin
        m_open = 1;
        m_L = (l > ML) ? ML : l;
        m_cnt = 0; m_sum = 0;
      end
      m_sum += dv;
      m_cnt++;
      if (m_cnt == (longint'(1) << m_L)) begin
        x.s = m_sum;
        x.m = floor_div(m_sum, m_L);
        q.push_back(x);
        m_open = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_data", longint'($signed(data_o)), 0);
    chk("rst_async_sum", longint'($signed(sum_o)), 0);
    chk("rst_async_valid", longint'(valid_o), 0);
    m_open = 0; m_cnt = 0; m_sum = 0;
    last_s = 0; last_m = 0;
    en = 0; clr = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_data", longint'($signed(data_o)), 0);
        chk("rst_sum", longint'($signed(sum_o)), 0);
        chk("rst_valid", longint'(valid_o), 0);
      end else if (valid_o) begin
        if (q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_valid: got strobe expected none at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("block_sum", longint'($signed(sum_o)), e.s);
          chk("block_mean", longint'($signed(data_o)), e.m);
          last_s = e.s; last_m = e.m;
        end
      end else begin
        chk("hold_sum", longint'($signed(sum_o)), last_s);
        chk("hold_mean", longint'($signed(data_o)), last_m);
      end
    end
  end

  initial begin
    #3;
    chk("reset_data", longint'($signed(data_o)), 0);
    chk("reset_sum", longint'($signed(sum_o)), 0);
    chk("reset_valid", longint'(valid_o), 0);
    #10 rst_n = 1'b1;

    // constant 100, L=2
    repeat (12) drive(1, 0, 100, 2);
    // floor behaviour at L=1
    drive(1, 0, -3, 1); drive(1, 0, -4, 1);
    drive(1, 0, 3, 1);  drive(1, 0, 4, 1);
    // L=0 pass-through ramp
    for (int i = 0; i < 8; i++) drive(1, 0, i, 0);
    drive(0, 0, 0, 0);
    // enable toggling, disabled-cycle data is garbage
    for (int i = 0; i < 16; i++)
      drive((i % 2) == 0, 0, (i % 2) ? 32767 : int'($urandom_range(0, 65535)), 2);
    // length change mid-block applies at next block
    drive(1, 0, 10, 2); drive(1, 0, 20, 2);
    drive(1, 0, 30, 3); drive(1, 0, 40, 3);
    for (int i = 0; i < 8; i++) drive(1, 0, i * 7 - 20, 3);
    // clamped length 15 -> 1024 samples
    for (int i = 0; i < 1024; i++) drive(1, 0, int'($urandom_range(0, 65535)), 15);
    // extremes at L=10
    for (int i = 0; i < 1024; i++) drive(1, 0, -32768, 10);
    for (int i = 0; i < 1024; i++) drive(1, 0, 32767, 10);
    // clear mid-block, then a clean block
    drive(1, 0, 500, 2); drive(1, 0, 600, 2);
    drive(1, 1, 700, 2);
    for (int i = 0; i < 4; i++) drive(1, 0, 11 * i, 2);
    // clear coinciding with the completing sample
    drive(1, 0, 1, 2); drive(1, 0, 2, 2); drive(1, 0, 3, 2);
    drive(1, 1, 4, 2);
    for (int i = 0; i < 4; i++) drive(1, 0, -5 * i, 2);
    // async reset mid-block
    drive(1, 0, 900, 2); drive(1, 0, 901, 2);
    drive(0, 0, 0, 2);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 0, 50 + i, 2);
    // randomized traffic with mid-block length changes and clears
    for (int i = 0; i < 3000; i++)
      drive(($urandom % 4) != 0, ($urandom % 64) == 0,
            int'($urandom_range(0, 65535)), int'($urandom_range(0, 4)));
    repeat (3) drive(0, 0, 0, 0);
    chk("pending_expected", longint'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
